// File: rtl/lsab_cw_pkg.sv
// ---------------------------------------------------------------------------
// lsab_cw_pkg
//   Shared constants, types and helpers for the four-channel load/store
//   assist buffer (CPU-write side).  Every FIFO is 32 words of 32 bits.
//   All four FIFOs live in one 128x32 RAM.  A FIFO's words are addressed
//   as {fifo index, pointer}.
// ---------------------------------------------------------------------------
package lsab_cw_pkg;

  localparam int FIFO_DEPTH = 32;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 6;
  localparam int DATA_W     = 32;
  localparam int NUM_FIFO   = 4;
  localparam int FIFO_IDX_W = 2;
  localparam int ADDR_W     = FIFO_IDX_W + PTR_W;
  localparam int RAM_WORDS  = NUM_FIFO * FIFO_DEPTH;

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [FIFO_IDX_W-1:0] fifo_idx_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  // A count of FIFO_DEPTH needs the extra sixth bit.  That is why counts
  // are one bit wider than the pointers.
  localparam cnt_t CNT_FULL  = cnt_t'(FIFO_DEPTH);
  localparam cnt_t CNT_EMPTY = '0;

  // One stage of the read pipeline.  The RAM output is registered, so a
  // read that is accepted this edge has its word ready one edge later.
  // At that edge the word is steered into OUT[fifo].
  typedef struct packed {
    logic      valid;
    fifo_idx_t fifo;
  } rd_pipe_t;

  // Builds the RAM address of a FIFO slot.  The FIFO index is in the upper
  // bits, so each FIFO owns a private 32-word region.  A pointer that wraps
  // therefore cannot reach another FIFO's region.
  function automatic addr_t ram_addr(input fifo_idx_t fifo, input ptr_t ptr);
    return {fifo, ptr};
  endfunction

endpackage

// File: rtl/lsab_ram.sv
// ---------------------------------------------------------------------------
// lsab_ram
//   128x32 simple dual-port RAM that holds all four FIFOs of lsab_cw.
//   Ports:
//     CLK      in   clock, rising edge
//     wr_en    in   write enable
//     wr_addr  in   7-bit write address {fifo, ptr}
//     wr_data  in   32-bit write data
//     rd_en    in   read enable; loads the output register
//     rd_addr  in   7-bit read address {fifo, ptr}
//     rd_data  out  32-bit registered read data
//   The RAM has no reset, so its contents survive a reset of the buffer.
// ---------------------------------------------------------------------------
module lsab_ram
  import lsab_cw_pkg::*;
(
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // The buffer never reads and writes the same address in one cycle:
  // a read needs a non-empty FIFO, and a write needs a non-full FIFO.
  // The two pointers can be equal only when the FIFO is empty or full.
  // For that reason the read-during-write behaviour does not matter here.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lsab_cw.sv
// ---------------------------------------------------------------------------
// lsab_cw
//   Four-channel load/store assist buffer, CPU-write side.  One shared
//   write port fills four independent 32-word FIFOs.  One shared read port
//   drains them.  Each FIFO has its own registered data output and a
//   registered full flag.
//   Ports:
//     CLK          in   clock, rising edge
//     RST          in   synchronous reset, active low
//     WRITE        in   write strobe; pushes IN into FIFO WRITE_FIFO
//     WRITE_FIFO   in   2-bit target FIFO index
//     IN           in   32-bit write data
//     READ         in   read strobe; pops FIFO READ_FIFO
//     READ_FIFO    in   2-bit source FIFO index
//     OUT_0..3     out  32-bit per-FIFO read data registers
//     BFULL_0..3   out  per-FIFO full flags (count == 32)
//   Read latency: OUT_n loads on the second rising edge after the READ.
//   The first edge samples READ; the next edge loads OUT_n.
// ---------------------------------------------------------------------------
module lsab_cw
  import lsab_cw_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              WRITE,
  input  logic [1:0]        WRITE_FIFO,
  input  logic [DATA_W-1:0] IN,
  input  logic              READ,
  input  logic [1:0]        READ_FIFO,
  output logic [DATA_W-1:0] OUT_0,
  output logic [DATA_W-1:0] OUT_1,
  output logic [DATA_W-1:0] OUT_2,
  output logic [DATA_W-1:0] OUT_3,
  output logic              BFULL_0,
  output logic              BFULL_1,
  output logic              BFULL_2,
  output logic              BFULL_3
);

  logic [PTR_W-1:0]    wp_q  [NUM_FIFO];
  logic [PTR_W-1:0]    wp_d  [NUM_FIFO];
  logic [PTR_W-1:0]    rp_q  [NUM_FIFO];
  logic [PTR_W-1:0]    rp_d  [NUM_FIFO];
  logic [CNT_W-1:0]    cnt_q [NUM_FIFO];
  logic [CNT_W-1:0]    cnt_d [NUM_FIFO];
  logic [DATA_W-1:0]   out_q [NUM_FIFO];
  logic [DATA_W-1:0]   out_d [NUM_FIFO];
  logic [NUM_FIFO-1:0] bfull_q;
  logic [NUM_FIFO-1:0] bfull_d;
  rd_pipe_t            rd_pipe_q;
  rd_pipe_t            rd_pipe_d;

  logic                wr_acc;
  logic                rd_acc;
  logic [ADDR_W-1:0]   ram_wr_addr;
  logic [ADDR_W-1:0]   ram_rd_addr;
  logic [DATA_W-1:0]   ram_rd_data;

  // Accept a write only when the FIFO has room, and a read only when the
  // FIFO holds data.  Both tests use the count from before this edge.
  // So on an empty FIFO, a write and a read in the same cycle accept the
  // write and ignore the read.  On a full FIFO the read is accepted and
  // the write is dropped.
  assign wr_acc      = WRITE && (cnt_q[WRITE_FIFO] != CNT_FULL);
  assign rd_acc      = READ  && (cnt_q[READ_FIFO]  != CNT_EMPTY);
  assign ram_wr_addr = ram_addr(WRITE_FIFO, wp_q[WRITE_FIFO]);
  assign ram_rd_addr = ram_addr(READ_FIFO,  rp_q[READ_FIFO]);

  // During reset the RAM write is suppressed.  A write that arrives in the
  // reset cycle then leaves no word behind the cleared pointers.
  lsab_ram u_ram (
    .CLK     (CLK),
    .wr_en   (wr_acc && RST),
    .wr_addr (ram_wr_addr),
    .wr_data (IN),
    .rd_en   (rd_acc),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    for (int n = 0; n < NUM_FIFO; n++) begin
      wp_d[n]  = wp_q[n];
      rp_d[n]  = rp_q[n];
      cnt_d[n] = cnt_q[n];
      out_d[n] = out_q[n];
    end

    // Pointers wrap naturally at 32 because they are exactly PTR_W wide.
    if (wr_acc) begin
      wp_d[WRITE_FIFO] = wp_q[WRITE_FIFO] + PTR_W'(1);
    end
    if (rd_acc) begin
      rp_d[READ_FIFO] = rp_q[READ_FIFO] + PTR_W'(1);
    end

    // If a FIFO accepts a write and a read in the same cycle, its count
    // does not change.
    for (int n = 0; n < NUM_FIFO; n++) begin
      case ({wr_acc && (WRITE_FIFO == 2'(n)), rd_acc && (READ_FIFO == 2'(n))})
        2'b10:   cnt_d[n] = cnt_q[n] + CNT_W'(1);
        2'b01:   cnt_d[n] = cnt_q[n] - CNT_W'(1);
        default: cnt_d[n] = cnt_q[n];
      endcase
    end

    // The RAM word fetched on the previous edge lands in its own channel.
    // The other channels keep their values.
    if (rd_pipe_q.valid) begin
      out_d[rd_pipe_q.fifo] = ram_rd_data;
    end

    rd_pipe_d.valid = rd_acc;
    rd_pipe_d.fifo  = READ_FIFO;

    // The full flag is computed from the next count.  It then changes on
    // the same edge as the write or read that caused it.
    for (int n = 0; n < NUM_FIFO; n++) begin
      bfull_d[n] = (cnt_d[n] == CNT_FULL);
    end
  end

  // Reset clears the pointers, counts, outputs and flags.  It also clears
  // the read pipeline, so a read that is in flight cannot load an OUT
  // register after the reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int n = 0; n < NUM_FIFO; n++) begin
        wp_q[n]  <= '0;
        rp_q[n]  <= '0;
        cnt_q[n] <= '0;
        out_q[n] <= '0;
      end
      bfull_q   <= '0;
      rd_pipe_q <= '0;
    end else begin
      for (int n = 0; n < NUM_FIFO; n++) begin
        wp_q[n]  <= wp_d[n];
        rp_q[n]  <= rp_d[n];
        cnt_q[n] <= cnt_d[n];
        out_q[n] <= out_d[n];
      end
      bfull_q   <= bfull_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign OUT_0   = out_q[0];
  assign OUT_1   = out_q[1];
  assign OUT_2   = out_q[2];
  assign OUT_3   = out_q[3];
  assign BFULL_0 = bfull_q[0];
  assign BFULL_1 = bfull_q[1];
  assign BFULL_2 = bfull_q[2];
  assign BFULL_3 = bfull_q[3];

endmodule

// File: tb/tb_lsab_cw.sv
// ---------------------------------------------------------------------------
// tb_lsab_cw
//   Self-checking bench for lsab_cw.  The reference model keeps one queue
//   per channel.  A read pops the head of its queue, and that word is
//   expected in OUT_n two edges after the strobe.  A write pushes onto the
//   queue when the queue holds fewer than 32 words.  BFULL_n is expected
//   when the queue holds exactly 32 words.
// ---------------------------------------------------------------------------
module tb_lsab_cw;

  logic        CLK;
  logic        RST;
  logic        WRITE;
  logic [1:0]  WRITE_FIFO;
  logic [31:0] IN;
  logic        READ;
  logic [1:0]  READ_FIFO;
  logic [31:0] OUT_0, OUT_1, OUT_2, OUT_3;
  logic        BFULL_0, BFULL_1, BFULL_2, BFULL_3;

  lsab_cw dut (
    .CLK        (CLK),
    .RST        (RST),
    .WRITE      (WRITE),
    .WRITE_FIFO (WRITE_FIFO),
    .IN         (IN),
    .READ       (READ),
    .READ_FIFO  (READ_FIFO),
    .OUT_0      (OUT_0),
    .OUT_1      (OUT_1),
    .OUT_2      (OUT_2),
    .OUT_3      (OUT_3),
    .BFULL_0    (BFULL_0),
    .BFULL_1    (BFULL_1),
    .BFULL_2    (BFULL_2),
    .BFULL_3    (BFULL_3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int check_count = 0;
  int fail_count  = 0;

  // Reference model state
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  logic [31:0] mq2 [$];
  logic [31:0] mq3 [$];
  logic [31:0] exp_out  [4];
  logic        exp_full [4];
  logic        pend_valid;
  int          pend_fifo;
  logic [31:0] pend_data;

  logic [31:0] dut_out  [4];
  logic        dut_full [4];
  assign dut_out[0]  = OUT_0;
  assign dut_out[1]  = OUT_1;
  assign dut_out[2]  = OUT_2;
  assign dut_out[3]  = OUT_3;
  assign dut_full[0] = BFULL_0;
  assign dut_full[1] = BFULL_1;
  assign dut_full[2] = BFULL_2;
  assign dut_full[3] = BFULL_3;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int qSize(input int f);
    case (f)
      0:       return mq0.size();
      1:       return mq1.size();
      2:       return mq2.size();
      default: return mq3.size();
    endcase
  endfunction

  task automatic qPop(input int f, output logic [31:0] d);
    case (f)
      0:       d = mq0.pop_front();
      1:       d = mq1.pop_front();
      2:       d = mq2.pop_front();
      default: d = mq3.pop_front();
    endcase
  endtask

  task automatic qPush(input int f, input logic [31:0] d);
    case (f)
      0:       mq0.push_back(d);
      1:       mq1.push_back(d);
      2:       mq2.push_back(d);
      default: mq3.push_back(d);
    endcase
  endtask

  // Advances the model by one rising edge with the given sampled inputs.
  task automatic modelEdge(input logic rst_n, input logic wr, input int wf,
                           input logic [31:0] din, input logic rd, input int rf);
    logic rd_ok;
    logic wr_ok;
    if (!rst_n) begin
      mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
      for (int n = 0; n < 4; n++) exp_out[n] = 32'h0;
      pend_valid = 1'b0;
    end else begin
      if (pend_valid) exp_out[pend_fifo] = pend_data;
      pend_valid = 1'b0;
      rd_ok = rd && (qSize(rf) > 0);
      wr_ok = wr && (qSize(wf) < 32);
      if (rd_ok) begin
        qPop(rf, pend_data);
        pend_fifo  = rf;
        pend_valid = 1'b1;
      end
      if (wr_ok) qPush(wf, din);
    end
    for (int n = 0; n < 4; n++) exp_full[n] = (qSize(n) == 32);
  endtask

  // Drives one cycle of inputs, lets the edge happen, then compares every
  // output with the model 1 ns after the edge.
  task automatic applyStimulus(input logic rst_n, input logic wr, input int wf,
                               input logic [31:0] din, input logic rd, input int rf);
    RST        = rst_n;
    WRITE      = wr;
    WRITE_FIFO = 2'(wf);
    IN         = din;
    READ       = rd;
    READ_FIFO  = 2'(rf);
    @(posedge CLK);
    modelEdge(rst_n, wr, wf, din, rd, rf);
    #1;
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("out%0d", n), dut_out[n], exp_out[n]);
      checkOutput($sformatf("bfull%0d", n), {31'h0, dut_full[n]}, {31'h0, exp_full[n]});
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pend_valid = 1'b0;
    pend_fifo  = 0;
    pend_data  = '0;
    for (int n = 0; n < 4; n++) begin
      exp_out[n]  = '0;
      exp_full[n] = 1'b0;
    end

    // Reset
    doReset();
    doReset();

    // Five words through FIFO 2
    $display("[TB] test 1: five words through FIFO 2");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 2, 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 2);
    idle(2);
    checkOutput("t1_out2_last", OUT_2, 32'h4);
    checkOutput("t1_out0_zero", OUT_0, 32'h0);

    // Fill FIFO 1, then a dropped 33rd write, then drain
    $display("[TB] test 2: fill FIFO 1 and overflow");
    for (int i = 0; i < 32; i++) applyStimulus(1, 1, 1, 32'h100 + 32'(i), 0, 0);
    checkOutput("t2_full_set", {31'h0, BFULL_1}, 32'h1);
    applyStimulus(1, 1, 1, 32'hDEAD, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("t2_full_clr", {31'h0, BFULL_1}, 32'h0);
    for (int i = 1; i < 32; i++) applyStimulus(1, 0, 0, 0, 1, 1);
    idle(2);
    checkOutput("t2_out1_last", OUT_1, 32'h11F);
    applyStimulus(1, 0, 0, 0, 1, 1);
    idle(2);
    checkOutput("t2_no_dead", OUT_1, 32'h11F);

    // Interleaved FIFO 0 / FIFO 3 traffic
    $display("[TB] test 3: interleaved FIFO 0 and 3");
    for (int i = 0; i < 24; i++)
      applyStimulus(1, 1, (i % 2) * 3, 32'h3000 + 32'(i), 1, ((i + 1) % 2) * 3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1, (i % 2) * 3);
    idle(2);

    // Read of an empty FIFO keeps OUT
    $display("[TB] test 4: read of empty FIFO 0");
    doReset();
    applyStimulus(1, 1, 0, 32'h55, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 1, 0);
    idle(2);
    checkOutput("t4_hold55", OUT_0, 32'h55);
    applyStimulus(1, 1, 0, 32'h66, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    idle(2);
    checkOutput("t4_new66", OUT_0, 32'h66);

    // Simultaneous write/read on FIFO 2 across the pointer wrap
    $display("[TB] test 5: streaming FIFO 2 across wrap");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 2, 32'h500 + 32'(i), 0, 0);
    for (int i = 5; i < 45; i++) applyStimulus(1, 1, 2, 32'h500 + 32'(i), 1, 2);
    checkOutput("t5_nofull", {31'h0, BFULL_2}, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 2);
    idle(2);
    checkOutput("t5_out2_last", OUT_2, 32'h500 + 32'd44);

    // Reset with reads in flight
    $display("[TB] test 6: reset with reads in flight");
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, (i % 2) ? 3 : 1, 32'h600 + 32'(i), 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("t6_out1_rst", OUT_1, 32'h0);
    checkOutput("t6_out3_rst", OUT_3, 32'h0);
    idle(2);
    checkOutput("t6_no_stale", OUT_1, 32'h0);
    applyStimulus(1, 1, 1, 32'h777, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1);
    idle(2);
    checkOutput("t6_new777", OUT_1, 32'h777);

    // Randomized traffic
    $display("[TB] test 7: random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 3)));
    end
    idle(3);

    $display("%0d/%0d checks passed", check_count - fail_count, check_count);
    $finish;
  end

endmodule
